wb_stage_pipe: RTL
==================

Name: wb_stage_pipe

Overview:
- Parametrised successor to the 2:1 writeback mux: a registered MEM/WB pipeline stage with a 3-source writeback select.
- Adds big-endian sub-word load extraction with sign/zero extension, register-write qualification, stall/flush control, misalignment detection and a retired-instruction counter.
- Sits between the data-memory stage and the register file write port. Its registered outputs drive the register file and the forwarding unit.

Parameters:
- DATA_W, 32, datapath width in bits; multiple of 8, at least 16.
- REG_AW, 5, register index width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- stall  input  1  hold all stage registers
- flush  input  1  squash the instruction being captured
- mem_valid  input  1  MEM stage holds a real instruction
- mem_regwrite  input  1  instruction writes a register
- mem_wbsel  input  2  result source: 00 ALU, 01 memory, 10 link (PC+8), 11 reserved
- mem_ldsize  input  2  load size: 00 word, 01 half, 10 byte, 11 reserved
- mem_ldsigned  input  1  sign-extend sub-word load
- mem_addr_lo  input  log2(DATA_W/8)  low byte address bits of the load
- mem_rd  input  REG_AW  destination register
- mem_aluout  input  DATA_W  ALU result
- mem_readdata  input  DATA_W  raw memory word
- mem_link  input  DATA_W  link address
- wb_valid  output  1  stage holds a retired instruction
- wb_regwrite  output  1  register file write enable
- wb_rd  output  REG_AW  register file write address
- wb_result  output  DATA_W  register file write data
- wb_align_err  output  1  misaligned load retired
- wb_retired  output  CNT_W  count of retired instructions

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: wb_valid, wb_regwrite, wb_align_err = 0; wb_rd = 0; wb_result = 0; wb_retired = 0. reset has priority over stall and flush.
- Registering: all outputs are registered. Latency is 1 cycle from MEM inputs to wb_* outputs. Result selection and extraction are combinational on the input side.
- Register update priority, each edge:
  - reset
  - else stall: hold every register, counter included.
  - else flush: wb_valid, wb_regwrite, wb_align_err = 0; wb_rd, wb_result unchanged.
  - else capture.
- Capture: wb_valid = mem_valid.
- Load extraction (big-endian). Byte offset k = mem_addr_lo; byte k occupies bits [DATA_W-1-8k -: 8].
  - byte: any k is legal.
  - half: k must be even; the half occupies [DATA_W-1-8k -: 16].
  - word (or reserved 11): k must be 0; the full readdata is passed.
  - Extension: if mem_ldsigned=1, replicate the MSB of the extracted field; otherwise zero-fill.
- Misalignment: misalign = mem_valid & (mem_wbsel==01) & an illegal offset for the load size.
  - wb_align_err = misalign.
  - A misaligned load still retires, but its write is suppressed.
- Source select: 00 ALU, 01 extracted load, 10 link, 11 ALU.
- Write enable: wb_regwrite = mem_valid & mem_regwrite & (mem_rd != 0) & ~misalign. Writes to register 0 never assert the write enable.
- Retire counter: wb_retired increments by 1 on every capture edge where mem_valid=1 (misaligned loads included). It wraps modulo 2^CNT_W and is unaffected by flush-squashed instructions.
- Simultaneous stall and flush: stall wins. The squash takes effect on the first unstalled edge only if flush is still asserted then.
- No handshake beyond stall. The producer holds its MEM inputs stable while stall is high.

Optional Feature:
- Macro: WB_HIST_EN.
- With the macro defined:
  - Extra outputs wb_hist_valid (1), wb_hist_rd (REG_AW) and wb_hist_data (DATA_W).
  - On each capture edge where the outgoing wb_regwrite was 1, these load the previous wb_rd/wb_result. This gives the forwarding unit a second-older bypass source.
  - All three reset to 0 and are held on stall.
  - On flush they are not cleared: the prior instruction already retired.
- Without the macro: the ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg:
  - wbsel enum: WB_ALU=2'b00, WB_MEM=2'b01, WB_LINK=2'b10
  - ldsize enum: LD_WORD=2'b00, LD_HALF=2'b01, LD_BYTE=2'b10
  - helper constant BYTES = DATA_W/8
- One sub-module: wb_load_align. It is purely combinational: readdata, ldsize, ldsigned and addr_lo in; extracted value and misalign flag out. It is instantiated once.

Test Plan:
- Reset: apply reset for 2 cycles with mem_valid=1 held -> all outputs 0. Release reset; the next edge captures and wb_retired=1.
- ALU write: wbsel=00, rd=5, aluout=0x0000_1234 -> the next cycle shows wb_regwrite=1, wb_rd=5, wb_result=0x0000_1234. Repeating with rd=0 gives wb_regwrite=0 and wb_valid=1.
- Byte load, readdata=0x80FF_7F01:
  - k=0 signed -> 0xFFFF_FF80
  - k=0 unsigned -> 0x0000_0080
  - k=2 signed -> 0x0000_007F
  - k=3 -> 0x0000_0001
- Misaligned loads: half load with k=1 -> wb_align_err=1, wb_regwrite=0, counter +1. Half k=2 signed on readdata=0x0000_8001 -> 0xFFFF_8001.
- Stall and flush:
  - stall high 3 cycles with changing inputs -> outputs and counter frozen.
  - stall and flush together -> held.
  - flush alone with mem_valid=1 -> wb_valid=0, wb_regwrite=0, counter unchanged.
- Link and counter wrap: wbsel=10, mem_link=0x0040_0008 -> wb_result=0x0040_0008. With CNT_W=4, 17 valid captures -> wb_retired=1.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the MEM/WB writeback stage.
//   wbsel_e  : writeback result source (ALU, memory load, link address)
//   ldsize_e : load size (word, half, byte); the encoding 2'b11 is reserved
//   BYTES    : bytes per word for the default 32-bit datapath
//   bytes_of : bytes per word for an arbitrary datapath width
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10
    } wbsel_e;

    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10
    } ldsize_e;

    localparam int DATA_W_DEFAULT = 32;
    localparam int BYTES          = DATA_W_DEFAULT / 8;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// -----------------------------------------------------------------------------
// wb_load_align
// Purely combinational big-endian sub-word load extractor.
// Byte k of the word occupies readdata[DATA_W-1-8k -: 8]; the extracted field
// is sign- or zero-extended to DATA_W bits.
//   readdata  in   DATA_W  raw memory word
//   ldsize    in   2       00 word, 01 half, 10 byte, 11 treated as word
//   ldsigned  in   1       sign-extend the extracted field
//   addr_lo   in   AW      byte offset within the word
//   extracted out  DATA_W  extended load value
//   off_err   out  1       offset is illegal for the load size
// A misaligned half load extracts the half at the offset rounded down to even
// and a misaligned word passes readdata unchanged; the value is never written
// to the register file because the write enable is suppressed.
// -----------------------------------------------------------------------------
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(bytes_of(DATA_W))
) (
    input  logic [DATA_W-1:0] readdata,
    input  logic [1:0]        ldsize,
    input  logic              ldsigned,
    input  logic [AW-1:0]     addr_lo,
    output logic [DATA_W-1:0] extracted,
    output logic              off_err
);

    localparam logic [AW-1:0] HALF_MASK = ~AW'(1);

    logic [AW-1:0]     half_off;
    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;
    logic [7:0]        byte_f;
    logic [15:0]       half_f;

    // Shifting left by 8*k moves byte k to the top of the word, which turns
    // the big-endian lane selection into a fixed part-select.
    assign half_off = addr_lo & HALF_MASK;
    assign byte_sh  = readdata << {addr_lo, 3'b000};
    assign half_sh  = readdata << {half_off, 3'b000};
    assign byte_f   = byte_sh[DATA_W-1 -: 8];
    assign half_f   = half_sh[DATA_W-1 -: 16];

    // NOTE: every output of a combinational block is given a default first so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        extracted = readdata;
        off_err   = 1'b0;
        case (ldsize)
            LD_BYTE: begin
                extracted = ldsigned ? DATA_W'($signed(byte_f)) : DATA_W'(byte_f);
                off_err   = 1'b0;
            end
            LD_HALF: begin
                extracted = ldsigned ? DATA_W'($signed(half_f)) : DATA_W'(half_f);
                off_err   = addr_lo[0];
            end
            default: begin
                extracted = readdata;
                off_err   = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// wb_stage_pipe
// Registered MEM/WB pipeline stage with a 3-source writeback select, big-endian
// sub-word load extraction, write qualification, stall/flush control,
// misalignment detection and a retired-instruction counter.
// Optional feature macro: WB_HIST_EN adds a second-older bypass register set
// (wb_hist_valid / wb_hist_rd / wb_hist_data) for the forwarding unit.
//   clk, reset        clock, synchronous active-high reset
//   stall, flush      hold all registers / squash the captured instruction
//   mem_*             MEM-stage instruction fields and data
//   wb_valid          stage holds a retired instruction
//   wb_regwrite       register file write enable
//   wb_rd, wb_result  register file write address and data
//   wb_align_err      misaligned load retired
//   wb_retired        retired-instruction count, wraps modulo 2^CNT_W
// Update priority per edge: reset, stall (hold), flush (squash), capture.
// -----------------------------------------------------------------------------
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              flush,
    input  logic                              mem_valid,
    input  logic                              mem_regwrite,
    input  logic [1:0]                        mem_wbsel,
    input  logic [1:0]                        mem_ldsize,
    input  logic                              mem_ldsigned,
    input  logic [$clog2(DATA_W/8)-1:0]       mem_addr_lo,
    input  logic [REG_AW-1:0]                 mem_rd,
    input  logic [DATA_W-1:0]                 mem_aluout,
    input  logic [DATA_W-1:0]                 mem_readdata,
    input  logic [DATA_W-1:0]                 mem_link,
`ifdef WB_HIST_EN
    output logic                              wb_hist_valid,
    output logic [REG_AW-1:0]                 wb_hist_rd,
    output logic [DATA_W-1:0]                 wb_hist_data,
`endif
    output logic                              wb_valid,
    output logic                              wb_regwrite,
    output logic [REG_AW-1:0]                 wb_rd,
    output logic [DATA_W-1:0]                 wb_result,
    output logic                              wb_align_err,
    output logic [CNT_W-1:0]                  wb_retired
);

    localparam int AW = $clog2(DATA_W / 8);

    logic [DATA_W-1:0] load_val;
    logic              off_err;
    logic              misalign;
    logic              regwrite_nxt;
    logic [DATA_W-1:0] result_nxt;

    wb_load_align #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_load_align (
        .readdata  (mem_readdata),
        .ldsize    (mem_ldsize),
        .ldsigned  (mem_ldsigned),
        .addr_lo   (mem_addr_lo),
        .extracted (load_val),
        .off_err   (off_err)
    );

    // Only a real memory-sourced instruction can be misaligned.
    assign misalign     = mem_valid & (mem_wbsel == WB_MEM) & off_err;
    assign regwrite_nxt = mem_valid & mem_regwrite & (mem_rd != '0) & ~misalign;

    always_comb begin
        result_nxt = mem_aluout;
        case (mem_wbsel)
            WB_MEM:  result_nxt = load_val;
            WB_LINK: result_nxt = mem_link;
            default: result_nxt = mem_aluout;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; the history registers below depend on that when
    // they copy the outgoing wb_rd/wb_result in the same edge that replaces them.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_align_err <= 1'b0;
            wb_rd        <= '0;
            wb_result    <= '0;
            wb_retired   <= '0;
        end else if (!stall) begin
            if (flush) begin
                // Squashed: destination and data keep their last values.
                wb_valid     <= 1'b0;
                wb_regwrite  <= 1'b0;
                wb_align_err <= 1'b0;
            end else begin
                wb_valid     <= mem_valid;
                wb_regwrite  <= regwrite_nxt;
                wb_align_err <= misalign;
                wb_rd        <= mem_rd;
                wb_result    <= result_nxt;
                if (mem_valid) begin
                    wb_retired <= wb_retired + CNT_W'(1);
                end
            end
        end
    end

`ifdef WB_HIST_EN
    // Second-older bypass source: keeps the last instruction that actually
    // wrote the register file; a flush does not clear it because that
    // instruction has already retired.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_hist_valid <= 1'b0;
            wb_hist_rd    <= '0;
            wb_hist_data  <= '0;
        end else if (!stall && !flush && wb_regwrite) begin
            wb_hist_valid <= 1'b1;
            wb_hist_rd    <= wb_rd;
            wb_hist_data  <= wb_result;
        end
    end
`endif

endmodule
